// File: rtl/bubblesort_ctrl.sv
// bubblesort_ctrl -- serial bubble-sort engine with stream in/out.
//
// Takes N unsigned W-bit elements over a valid/ready stream, sorts them in
// place in a register bank with a single compare-swap unit (one compare per
// clock), then streams them out smallest first.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input stream handshake, in_data = element
//   out_valid/out_ready output stream handshake, out_data = sorted element
//   out_last            marks the Nth (largest) output element
//   busy                high while sorting or draining
//   done                one-cycle pulse on the first drain cycle
//   cmp_count           compares performed by the most recent job
//
// Build option: define BSORT_EARLY_EXIT_EN to end the sort after the first
// pass that performs no swap.

module bubblesort_ctrl #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [W-1:0]                         in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [W-1:0]                         out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(N*(N-1)/2+1)-1:0]       cmp_count
);

  localparam int C  = N * (N - 1) / 2;
  localparam int CW = $clog2(C + 1);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t state, state_nxt;

  logic [N-1:0][W-1:0] bank;
  logic [IW-1:0]       wr_idx, rd_idx, idx, idx1, pass;
  logic [CW-1:0]       cyc;

  logic [W-1:0] a, b;
  logic         do_swap, last_cmp, last_pass, sort_exit;
  logic         accept, last_acc, out_hs, last_out;

`ifdef BSORT_EARLY_EXIT_EN
  logic swapped;
`endif

  // compare-swap operands and pass bookkeeping
  always_comb begin
    idx1      = idx + IW'(1);
    a         = bank[idx];
    b         = bank[idx1];
    do_swap   = a > b;            // strict: equal values never move
    last_cmp  = ({1'b0, idx} + {1'b0, pass}) == (IW+1)'(N - 2);
    last_pass = pass == IW'(N - 2);
`ifdef BSORT_EARLY_EXIT_EN
    // a pass without any swap means the bank is already ordered
    sort_exit = last_cmp && (last_pass || !(swapped || do_swap));
`else
    sort_exit = last_cmp && last_pass;
`endif
    accept    = in_valid && (state == LOAD);
    last_acc  = accept && (wr_idx == IW'(N - 1));
    out_hs    = out_ready && (state == DRAIN);
    last_out  = out_hs && (rd_idx == IW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (last_acc) state_nxt = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_exit) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = bank[rd_idx];
        out_last  = rd_idx == IW'(N - 1);
        if (last_out) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank      <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      idx       <= '0;
      pass      <= '0;
      cyc       <= '0;
      cmp_count <= '0;
      done      <= 1'b0;
`ifdef BSORT_EARLY_EXIT_EN
      swapped   <= 1'b0;
`endif
    end else begin
      // the cycle after the last compare is the first drain cycle
      done <= (state == SORT) && sort_exit;
      case (state)
        LOAD: begin
          if (accept) begin
            bank[wr_idx] <= in_data;
            wr_idx       <= last_acc ? '0 : wr_idx + IW'(1);
          end
          if (last_acc) begin
            idx  <= '0;
            pass <= '0;
            cyc  <= '0;
`ifdef BSORT_EARLY_EXIT_EN
            swapped <= 1'b0;
`endif
          end
        end
        SORT: begin
          if (do_swap) begin
            bank[idx]  <= b;
            bank[idx1] <= a;
          end
          cyc <= cyc + CW'(1);
          if (last_cmp) begin
            idx  <= '0;
            pass <= pass + IW'(1);
          end else begin
            idx  <= idx1;
          end
`ifdef BSORT_EARLY_EXIT_EN
          swapped <= last_cmp ? 1'b0 : (swapped | do_swap);
`endif
          if (sort_exit) begin
            cmp_count <= cyc + CW'(1);
            rd_idx    <= '0;
          end
        end
        DRAIN: begin
          if (out_hs) rd_idx <= last_out ? '0 : rd_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bubblesort_ctrl.sv
module tb_bubblesort_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [7:0] in_data, out_data;
  logic [3:0] cmp_count;

  int checks = 0;
  int failures = 0;

  bubblesort_ctrl #(.N(5), .W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .cmp_count(cmp_count)
  );

  always #5 clk = ~clk;

`ifdef BSORT_EARLY_EXIT_EN
  localparam int SORTED_CMP = 4;
  localparam int SORTED_LAT = 5;
`else
  localparam int SORTED_CMP = 10;
  localparam int SORTED_LAT = 11;
`endif

  // element 0 in the low byte
  function automatic logic [4:0][7:0] pk(input logic [7:0] e0, e1, e2, e3, e4);
    pk = {e4, e3, e2, e1, e0};
  endfunction

  // Feeds five elements back to back; with junk set, leaves in_valid high
  // carrying 99 afterwards. Starts and ends at posedge+1.
  task automatic load_job(input logic [4:0][7:0] v, input bit junk);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      @(posedge clk); #1;
    end
    in_valid = junk;
    in_data  = junk ? 8'd99 : 8'd0;
  endtask

  // Collects five output handshakes; out_ready follows pat[k%4].
  task automatic drain(input logic [3:0] pat,
                       output logic [4:0][7:0] d, output logic [4:0] lasts,
                       output int lat, output int done_cnt, output bit done_first,
                       output int unstable, output bit inrdy_seen, output bit tmo);
    int n = 0;
    int k = 0;
    bit seen = 0;
    bit pstall = 0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    lat = 1; done_cnt = 0; done_first = 0; unstable = 0; inrdy_seen = 0;
    d = '0; lasts = '0;
    while (n < 5 && k < 300) begin
      out_ready = pat[k % 4];
      @(negedge clk);
      if (done) done_cnt++;
      if (out_valid) begin
        if (!seen) begin seen = 1; done_first = done; end
        if (pstall && (out_data !== pd || out_last !== pl)) unstable++;
        if (in_ready) inrdy_seen = 1;
        pstall = !out_ready; pd = out_data; pl = out_last;
        if (out_ready) begin d[n] = out_data; lasts[n] = out_last; n++; end
      end else if (!seen) begin
        lat++;
      end
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b0;
    tmo = (n < 5);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (cmp_count !== 4'd0) begin failures++; $display("FAIL reset_cmp_count got=%0d exp=0", cmp_count); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [4:0][7:0] d, e; logic [4:0] l; int lat, dc, us; bit df, ir, tmo;
    e = pk(12, 14, 15, 16, 17);
    load_job(pk(16, 14, 15, 17, 12), 0);
    drain(4'hF, d, l, lat, dc, df, us, ir, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (d[i] !== e[i]) begin failures++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, d[i], e[i]); end
    end
    checks++; if (l !== 5'b10000) begin failures++; $display("FAIL basic_last got=%b exp=10000", l); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
    checks++; if (df !== 1'b1) begin failures++; $display("FAIL basic_done_first got=%b exp=1", df); end
    checks++; if (cmp_count !== 4'd10) begin failures++; $display("FAIL basic_cmp_count got=%0d exp=10", cmp_count); end
    checks++; if (lat !== 11) begin failures++; $display("FAIL basic_latency got=%0d exp=11", lat); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_back_to_load got=%b%b exp=10", in_ready, busy); end
  endtask

  task automatic test_sorted();
    logic [4:0][7:0] d, e; logic [4:0] l; int lat, dc, us; bit df, ir, tmo;
    e = pk(1, 2, 3, 4, 5);
    load_job(pk(1, 2, 3, 4, 5), 0);
    drain(4'hF, d, l, lat, dc, df, us, ir, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL sorted_timeout got=1 exp=0"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (d[i] !== e[i]) begin failures++; $display("FAIL sorted_data[%0d] got=%0d exp=%0d", i, d[i], e[i]); end
    end
    checks++; if (cmp_count !== 4'(SORTED_CMP)) begin failures++; $display("FAIL sorted_cmp_count got=%0d exp=%0d", cmp_count, SORTED_CMP); end
    checks++; if (lat !== SORTED_LAT) begin failures++; $display("FAIL sorted_latency got=%0d exp=%0d", lat, SORTED_LAT); end
    checks++; if (dc !== 1 || df !== 1'b1) begin failures++; $display("FAIL sorted_done got=%0d/%b exp=1/1", dc, df); end
  endtask

  task automatic test_dups();
    logic [4:0][7:0] d, e; logic [4:0] l; int lat, dc, us; bit df, ir, tmo;
    e = pk(0, 3, 7, 7, 255);
    load_job(pk(7, 7, 3, 255, 0), 0);
    drain(4'hF, d, l, lat, dc, df, us, ir, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL dups_timeout got=1 exp=0"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (d[i] !== e[i]) begin failures++; $display("FAIL dups_data[%0d] got=%0d exp=%0d", i, d[i], e[i]); end
    end
    checks++; if (l !== 5'b10000) begin failures++; $display("FAIL dups_last got=%b exp=10000", l); end
    checks++; if (cmp_count !== 4'd10) begin failures++; $display("FAIL dups_cmp_count got=%0d exp=10", cmp_count); end
  endtask

  task automatic test_stall();
    logic [4:0][7:0] d, e; logic [4:0] l; int lat, dc, us; bit df, ir, tmo;
    e = pk(12, 14, 15, 16, 17);
    load_job(pk(16, 14, 15, 17, 12), 0);
    drain(4'b1001, d, l, lat, dc, df, us, ir, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL stall_timeout got=1 exp=0"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (d[i] !== e[i]) begin failures++; $display("FAIL stall_data[%0d] got=%0d exp=%0d", i, d[i], e[i]); end
    end
    checks++; if (l !== 5'b10000) begin failures++; $display("FAIL stall_last got=%b exp=10000", l); end
    checks++; if (us !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", us); end
    checks++; if (ir !== 1'b0) begin failures++; $display("FAIL stall_in_ready_drain got=%b exp=0", ir); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL stall_done_count got=%0d exp=1", dc); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_in_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_junk();
    logic [4:0][7:0] d, e; logic [4:0] l; int lat, dc, us; bit df, ir, tmo;
    e = pk(0, 3, 7, 7, 255);
    load_job(pk(255, 7, 0, 7, 3), 1);
    drain(4'b1011, d, l, lat, dc, df, us, ir, tmo);
    in_valid = 1'b0; in_data = '0;
    checks++; if (tmo) begin failures++; $display("FAIL junk_timeout got=1 exp=0"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (d[i] !== e[i]) begin failures++; $display("FAIL junk_data[%0d] got=%0d exp=%0d", i, d[i], e[i]); end
    end
    e = pk(5, 6, 7, 8, 9);
    load_job(pk(9, 8, 7, 6, 5), 0);
    drain(4'hF, d, l, lat, dc, df, us, ir, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL junk_next_timeout got=1 exp=0"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (d[i] !== e[i]) begin failures++; $display("FAIL junk_next_data[%0d] got=%0d exp=%0d", i, d[i], e[i]); end
    end
    checks++; if (l !== 5'b10000) begin failures++; $display("FAIL junk_next_last got=%b exp=10000", l); end
  endtask

  task automatic test_midreset();
    logic [4:0][7:0] d, e; logic [4:0] l; int lat, dc, us; bit df, ir, tmo;
    e = pk(1, 2, 3, 4, 5);
    load_job(pk(16, 14, 15, 17, 12), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    checks++; if (cmp_count !== 4'd0) begin failures++; $display("FAIL midrst_cmp_count got=%0d exp=0", cmp_count); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    load_job(pk(5, 4, 3, 2, 1), 0);
    drain(4'hF, d, l, lat, dc, df, us, ir, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL midrst_timeout got=1 exp=0"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (d[i] !== e[i]) begin failures++; $display("FAIL midrst_data[%0d] got=%0d exp=%0d", i, d[i], e[i]); end
    end
    checks++; if (cmp_count !== 4'd10) begin failures++; $display("FAIL midrst_cmp_count_after got=%0d exp=10", cmp_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sorted();
    test_dups();
    test_stall();
    test_junk();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bubblesort_ctrl.md
Name: bubblesort_ctrl

Overview:
- Sequential bubble-sort engine and controller for 8-bit sort vectors.
- Accepts N elements serially over a valid/ready stream, holds them in an internal register bank and sorts them in place with one shared compare-swap unit, one compare per cycle.
- Streams the result out in ascending order.
- Replaces the wide all-parallel sorter wherever area matters more than latency; sits between a producer FIFO and a consumer stream.

Parameters:
- N, 5, number of elements per sort job (N >= 2)
- W, 8, element width in bits

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has an element on in_data
- in_ready  output  1  block accepts an element this cycle
- in_data  input  W  element, unsigned
- out_valid  output  1  out_data holds a sorted element
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  W  sorted element, smallest first
- out_last  output  1  marks the Nth (largest) output element
- busy  output  1  high in SORT and DRAIN
- done  output  1  one-cycle pulse on the first DRAIN cycle
- cmp_count  output  $clog2(N*(N-1)/2+1)  compares performed in the most recent job

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: FSM=LOAD, all counters 0, register bank 0, in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, done=0, cmp_count=0.
- FSM states: LOAD, SORT, DRAIN.
- LOAD state:
  - in_ready=1.
  - On in_valid&&in_ready, write in_data to bank[wr_idx] and increment wr_idx.
  - On the Nth accept, go to SORT next cycle and clear wr_idx, pass and idx.
- SORT state:
  - in_ready=0; in_valid is ignored and no data is lost or stored.
  - Each cycle, compare bank[idx] with bank[idx+1]. Swap only if bank[idx] > bank[idx+1] (unsigned, strictly greater), so equal values are never swapped.
  - idx runs 0..N-2-pass. At the end of a pass, pass increments and idx returns to 0.
  - After pass N-2 completes, go to DRAIN.
  - Full job = C = N(N-1)/2 SORT cycles (10 for N=5).
  - A cycle counter increments once per SORT cycle. It is copied to cmp_count on SORT exit.
- DRAIN state:
  - out_valid=1 and out_data=bank[rd_idx], with rd_idx starting at 0.
  - rd_idx advances on out_valid&&out_ready.
  - out_last=1 while rd_idx=N-1.
  - On the handshake with out_last, go to LOAD next cycle with in_ready=1. Back-to-back jobs are allowed.
  - While out_valid&&!out_ready, out_data and out_last hold stable.
- done:
  - Asserts for exactly one cycle, coincident with the first out_valid cycle of the job.
  - out_valid rises in the cycle immediately after the last SORT cycle.
- busy=1 in SORT and DRAIN, 0 in LOAD.
- Reset mid-operation (any state): the job is discarded and all outputs return to their reset values immediately. The next job starts from wr_idx=0.
- Partial load: the block waits indefinitely in LOAD. There is no timeout.
- cmp_count holds its value until the next SORT exit and is unaffected by LOAD/DRAIN.

Optional Feature:
- Macro: BSORT_EARLY_EXIT_EN
- Defined:
  - A per-pass swapped flag is cleared at pass start and set on any swap.
  - If a pass ends with swapped=0, go directly to DRAIN, skipping the remaining passes.
  - cmp_count reports the compares actually performed. Minimum is N-1 for already-sorted input.
- Undefined: every job takes exactly C SORT cycles regardless of data, and cmp_count always equals C.

Test Plan:
- Load 16,14,15,17,12 with out_ready=1 -> out 12,14,15,16,17; out_last on 17; done pulses once; cmp_count=10.
- Load 1,2,3,4,5 -> out 1,2,3,4,5; cmp_count=4 with BSORT_EARLY_EXIT_EN, 10 without; out_valid rises 5 or 11 cycles after the last accept respectively.
- Load 7,7,3,255,0 -> out 0,3,7,7,255. Duplicates are preserved and the boundary values 0 and 255 sort correctly.
- Job 16,14,15,17,12 with out_ready toggling 1,0,0,1,... -> out_data and out_last stay stable while stalled; the sequence is unchanged; in_ready stays 0 until after the out_last handshake.
- Drive in_valid=1 with data 99 throughout SORT and DRAIN -> no value 99 appears in the output; the next job sorts only its own 5 elements.
- Pull rst_n low on the 3rd SORT cycle -> out_valid=0, busy=0, in_ready=1 asynchronously; then reload 5,4,3,2,1 -> out 1,2,3,4,5.
